// File: rtl/mem_pkg.sv
// Shared constants for the cache-fill memory responder: default geometry,
// response source encodings and the cache block size.
package mem_pkg;

  // Default geometry of the responder.
  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 16;
  localparam int MEM_LATENCY    = 4;

  // Legal latency window for the read pipeline.
  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 8;

  // Source tag carried with every read response.
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  // Words in one cache block fill.
  localparam int WORDS_PER_BLOCK = 8;

  // True when a latency value is inside the supported window.
  function automatic bit latency_ok(input int lat);
    return (lat >= MEM_LATENCY_MIN) && (lat <= MEM_LATENCY_MAX);
  endfunction

endpackage : mem_pkg

// File: rtl/rd_pipe.sv
// Fixed-depth read return pipeline. Each stage holds {valid, src, data};
// the pipe shifts every cycle and never stalls. Only the valid bits are
// reset, so a reset discards every in-flight read. Outputs are masked with
// the last-stage valid so that idle/reset values are all zero.
module rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_WIDTH,
  parameter int STAGES = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic              i_src,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic              o_src,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  logic [STAGES-1:0] r_vld_p;
  logic [STAGES-1:0] r_src_p;
  logic [DATA_W-1:0] r_data_p [STAGES];

  // Valid bits shift toward the output; async reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= i_vld;
      for (int i = 1; i < STAGES; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
    end
  end

  // Source tag and data shift alongside valid; no reset needed.
  always_ff @(posedge clk) begin
    r_src_p[0]  <= i_src;
    r_data_p[0] <= i_data;
    for (int i = 1; i < STAGES; i++) begin
      r_src_p[i]  <= r_src_p[i-1];
      r_data_p[i] <= r_data_p[i-1];
    end
  end

  // Output from the last stage, forced to zero when no response is present.
  always_comb begin
    o_vld  = r_vld_p[STAGES-1];
    o_src  = r_vld_p[STAGES-1] & r_src_p[STAGES-1];
    o_data = r_vld_p[STAGES-1] ? r_data_p[STAGES-1] : '0;
    o_busy = |r_vld_p;
  end

endmodule : rd_pipe

// File: rtl/multicycle_mem_ctrl.sv
// Shared fixed-latency memory responder for the I-cache and D-cache miss
// paths. Accepts at most one request per cycle with the instruction side
// winning, commits writes at the acceptance edge and returns read data a
// fixed LATENCY cycles later, tagged with its source.
module multicycle_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int LATENCY    = MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  i_grant,
  output logic                  d_grant,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  rdata_src,
  output logic                  busy
);

  // Word index drops the byte-select bit; storage covers the full index range.
  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam int DEPTH = 1 << IDX_W;

  // Clamp an out-of-window latency into the supported range.
  localparam int PIPE_STAGES = latency_ok(LATENCY) ? LATENCY :
                               ((LATENCY < MEM_LATENCY_MIN) ? MEM_LATENCY_MIN
                                                            : MEM_LATENCY_MAX);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_i_grant;
  logic                  w_d_grant;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_rd_src;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused_bits;

  // Fixed-priority arbiter; nothing is accepted while reset is asserted.
  always_comb begin
    w_i_grant = i_req & ~rst;
    w_d_grant = d_req & ~i_req & ~rst;
    w_wr_en   = w_d_grant & d_wr;
    w_rd_en   = w_i_grant | (w_d_grant & ~d_wr);
    w_rd_src  = w_i_grant ? SRC_I : SRC_D;
    w_idx     = w_i_grant ? i_addr[ADDR_WIDTH-1:1] : d_addr[ADDR_WIDTH-1:1];
  end

  assign i_grant = w_i_grant;
  assign d_grant = w_d_grant;

  // Byte-select bits are intentionally ignored.
  assign w_unused_bits = i_addr[0] ^ d_addr[0];

  // Read port samples the array as it stands before this edge's write.
  assign w_rd_word = r_mem[w_idx];

  // Storage write at the acceptance edge; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= d_wdata;
    end
  end

  rd_pipe #(
    .DATA_W (DATA_WIDTH),
    .STAGES (PIPE_STAGES)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_rd_en),
    .i_src  (w_rd_src),
    .i_data (w_rd_word),
    .o_vld  (rdata_valid),
    .o_src  (rdata_src),
    .o_data (rdata),
    .o_busy (busy)
  );

endmodule : multicycle_mem_ctrl

// File: doc/multicycle_mem_ctrl.md
# multicycle_mem_ctrl

Shared, fixed-latency, pipelined main-memory responder serving the instruction-cache and data-cache miss paths. It sits between the two caches and main memory storage: it arbitrates one request per cycle (instruction side first), commits writes immediately and returns read data exactly LATENCY cycles after acceptance, with a per-word valid strobe and source tag. It is the responder end of the cache-fill protocol driven by the caches' stall/fill logic.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte address width; word index = addr[ADDR_WIDTH-1:1]
- DATA_WIDTH, 16, word width
- LATENCY, 4, cycles from acceptance edge to rdata_valid; legal range 1..8

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction-side read request; held until granted
- i_addr  in  ADDR_WIDTH  instruction-side byte address
- d_req  in  1  data-side request; held with d_wr/d_addr/d_wdata stable until granted
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data-side byte address
- d_wdata  in  DATA_WIDTH  write data
- i_grant  out  1  instruction request accepted this cycle (combinational)
- d_grant  out  1  data request accepted this cycle (combinational)
- rdata  out  DATA_WIDTH  returned read word
- rdata_valid  out  1  rdata valid this cycle, one pulse per accepted read
- rdata_src  out  1  0 = instruction side, 1 = data side
- busy  out  1  at least one read in flight

## Operation
- Arbitration: i_grant = i_req; d_grant = d_req & ~i_req. At most one acceptance per cycle; fixed priority to instruction side; the data side is held off until the instruction stream pauses.
- Address: addr[0] ignored; word index = addr[ADDR_WIDTH-1:1]; no wrap beyond array top (index is full range).
- Write (d_grant & d_wr): storage word updated at the acceptance edge; no response, no pipeline slot.
- Read (any other grant): storage sampled at the acceptance edge, i.e. reflects every write accepted in earlier cycles; word, valid and source enter a LATENCY-deep read pipeline.
- Read pipeline: shift register of {valid, src, data}, advances every cycle, never stalls; output taken from last stage.
- busy = OR of all pipeline valid bits.
- Storage contents undefined at power-up, untouched by rst; benches preload through the write path.
- Reset (any time, including mid-fill): all pipeline valid bits cleared asynchronously; in-flight reads are discarded and never reported.
- Reset values: rdata_valid 0, rdata_src 0, rdata 0, busy 0; i_grant/d_grant follow inputs (combinational) but nothing is accepted while rst is high (grants forced 0 during rst).

## Timing
- Read accepted at edge t -> rdata_valid high for exactly the cycle following edge t+LATENCY-1 (LATENCY=4: visible in the 4th cycle after the request cycle).
- Sustained throughput: one read per cycle; an 8-word block fill of consecutive requests returns 8 consecutive valid cycles.
- Return order equals acceptance order; no reordering across sources.
- Write then read of same word in consecutive cycles: read returns new data. Read then write of same word: read returns old data.
- Simultaneous i_req and d_req: instruction accepted; data held, accepted first cycle i_req is low.
- Deassertion of rst: first acceptance possible in the cycle after rst falls.

## Structure
- Shared package mem_pkg: ADDR_WIDTH/DATA_WIDTH/LATENCY defaults, source constants SRC_I = 1'b0, SRC_D = 1'b1, block size constant WORDS_PER_BLOCK = 8.
- One sub-module: rd_pipe (parameterised LATENCY shift register of {valid, src, data} with async clear of valid bits); top holds arbiter, storage array and busy OR.

## Test plan
- Reset; d write 0x0010 = 0xBEEF, next cycle d read 0x0010 -> rdata_valid 4 cycles after read acceptance, rdata 0xBEEF, rdata_src 1.
- i_req 0x0000 and d_req read 0x0002 same cycle -> i_grant 1, d_grant 0; d accepted next cycle; returns mem[0] src 0 then mem[1] src 1 on consecutive cycles.
- 8 consecutive i reads 0x0100..0x010E (preloaded 0x1000..0x1007) -> 8 back-to-back valid cycles with those values in order; busy high from first acceptance until last valid cycle, then 0.
- d read 0x0020 (holds 0x1111) then d write 0x0020 = 0x2222 next cycle -> read returns 0x1111; a later read returns 0x2222.
- Read accepted, rst pulsed 2 cycles later -> rdata_valid never asserts, busy 0 immediately on rst, outputs at reset values.
- Read 0x0011 after write 0x0010 = 0xA5A5 -> returns 0xA5A5 (addr[0] ignored).
